// File: rtl/axi_burst_splitter_pkg.sv
// Shared constants and types for the AXI burst splitter (AXI_BURST_STATS_EN adds stat counters in the top).
package axi_burst_splitter_pkg;

  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH      = 32;
  localparam int DEF_LEN_WIDTH       = 26;
  localparam int DEF_MAX_BURST_BEATS = 16;
  localparam int AXI_4K_BYTES        = 4096;
  localparam int BYTES_PER_BEAT      = DEF_DATA_WIDTH / 8;
  localparam int AXI_SIZE            = $clog2(BYTES_PER_BEAT);

  typedef enum logic [1:0] {IDLE, CALC, ISSUE} burst_state_e;

  typedef struct packed {
    logic [DEF_ADDR_WIDTH-1:0] addr;
    logic [7:0]                len;
    logic                      last;
  } burst_req_t;

  function automatic int axi_size_of(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_burst_len_calc.sv
// Beats for the next burst: min(remaining, MAX_BURST_BEATS, beats left before the 4 KB boundary).
module axi_burst_len_calc
  import axi_burst_splitter_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int MAX_BURST_BEATS = DEF_MAX_BURST_BEATS
) (
  input  logic [11:0]          addr_lo,
  input  logic [LEN_WIDTH-1:0] remaining,
  output logic [8:0]           beats
);

  localparam int SIZE = axi_size_of(DATA_WIDTH);
  localparam int CW   = (LEN_WIDTH > 13) ? LEN_WIDTH : 13;

  logic [12:0] room;
  logic [8:0]  lim;

  always_comb begin
    // addr is beat-aligned, so the division is exact
    room  = (13'(AXI_4K_BYTES) - {1'b0, addr_lo}) >> SIZE;
    lim   = (room > 13'(MAX_BURST_BEATS)) ? 9'(MAX_BURST_BEATS) : room[8:0];
    beats = (CW'(remaining) < CW'(lim)) ? 9'(remaining) : lim;
  end

endmodule

// File: rtl/axi_burst_splitter.sv
// Splits a (start address, byte count) command into 4 KB-safe AXI4 INCR bursts.
// Define AXI_BURST_STATS_EN to add the stat_cmds/stat_bursts saturating counters.
module axi_burst_splitter
  import axi_burst_splitter_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int LEN_WIDTH       = DEF_LEN_WIDTH,
  parameter int MAX_BURST_BEATS = DEF_MAX_BURST_BEATS
) (
  input  logic                  axi_aclk,
  input  logic                  axi_reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_bytes,
  output logic                  cmd_error,
  output logic                  burst_valid,
  input  logic                  burst_ready,
  output logic [ADDR_WIDTH-1:0] burst_addr,
  output logic [7:0]            burst_len,
  output logic [2:0]            burst_size,
  output logic                  burst_last,
  output logic                  busy
`ifdef AXI_BURST_STATS_EN
  ,
  output logic [31:0]           stat_cmds,
  output logic [31:0]           stat_bursts
`endif
);

  localparam int BPB  = DATA_WIDTH / 8;
  localparam int SIZE = $clog2(BPB);

  // Same shape as the package request, with the address sized to this instance
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [7:0]            len;
    logic                  last;
  } req_t;

  burst_state_e          state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LEN_WIDTH-1:0]  rem_q;
  logic [LEN_WIDTH-1:0]  cmd_beats;
  logic [8:0]            beats_q, beats_calc;
  req_t                  req_q;
  logic                  cmd_fire, cmd_bad, burst_fire;

  assign cmd_fire   = (state == IDLE) && cmd_valid;
  assign cmd_bad    = (cmd_bytes == '0) || (|cmd_addr[SIZE-1:0]);
  assign burst_fire = (state == ISSUE) && burst_ready;
  assign cmd_beats  = LEN_WIDTH'(({1'b0, cmd_bytes} + (LEN_WIDTH+1)'(BPB - 1)) >> SIZE);

  axi_burst_len_calc #(
    .DATA_WIDTH      (DATA_WIDTH),
    .LEN_WIDTH       (LEN_WIDTH),
    .MAX_BURST_BEATS (MAX_BURST_BEATS)
  ) u_len_calc (
    .addr_lo   (addr_q[11:0]),
    .remaining (rem_q),
    .beats     (beats_calc)
  );

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) state <= IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cmd_fire && !cmd_bad) state_nxt = CALC;
      CALC:    state_nxt = ISSUE;
      ISSUE:   if (burst_fire) state_nxt = req_q.last ? IDLE : CALC;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      addr_q    <= '0;
      rem_q     <= '0;
      beats_q   <= '0;
      req_q     <= '0;
      cmd_error <= 1'b0;
    end else begin
      cmd_error <= cmd_fire && cmd_bad;
      if (cmd_fire && !cmd_bad) begin
        addr_q <= cmd_addr;
        rem_q  <= cmd_beats;
      end
      if (state == CALC) begin
        req_q.addr <= addr_q;
        req_q.len  <= 8'(beats_calc - 9'd1);
        req_q.last <= (LEN_WIDTH'(beats_calc) == rem_q);
        beats_q    <= beats_calc;
      end
      // wrap past the top of the address space is silent
      if (burst_fire) begin
        addr_q <= addr_q + (ADDR_WIDTH'(beats_q) << SIZE);
        rem_q  <= rem_q - LEN_WIDTH'(beats_q);
      end
    end
  end

  assign cmd_ready   = (state == IDLE);
  assign busy        = (state != IDLE);
  assign burst_valid = (state == ISSUE);
  assign burst_addr  = req_q.addr;
  assign burst_len   = req_q.len;
  assign burst_last  = req_q.last;
  assign burst_size  = 3'(SIZE);

`ifdef AXI_BURST_STATS_EN
  always_ff @(posedge axi_aclk) begin
    if (axi_reset) begin
      stat_cmds   <= '0;
      stat_bursts <= '0;
    end else begin
      if (cmd_fire && !cmd_bad && stat_cmds != '1) stat_cmds <= stat_cmds + 32'd1;
      if (burst_fire && stat_bursts != '1)         stat_bursts <= stat_bursts + 32'd1;
    end
  end
`endif

endmodule
